// File: rtl/mycpu_pkg.sv
// mycpu_pkg: definitions shared by the fetch stage and its FIFO.
//   - instruction field bit positions (cond, op, funct, rd)
//   - fetch FSM state encoding
//   - default reset PC
package mycpu_pkg;

  localparam int COND_HI  = 31;
  localparam int COND_LO  = 28;
  localparam int OP_HI    = 27;
  localparam int OP_LO    = 26;
  localparam int FUNCT_HI = 25;
  localparam int FUNCT_LO = 20;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 12;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO holding prefetched {word, addr} entries.
// Ports:
//   clk    in   clock, all state on posedge
//   reset  in   asynchronous active-low reset; entries load RST_VAL
//   push   in   write wdata at tail (accepted when not full, or full with pop)
//   wdata  in   entry to write
//   pop    in   remove head (ignored when empty)
//   flush  in   discard all entries; wins over push/pop
//   rdata  out  head entry (no bypass: a pushed entry appears the next cycle)
//   empty  out  no entries held
//   full   out  DEPTH entries held
//   count  out  number of entries held
module fetch_fifo
  import mycpu_pkg::*;
#(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 64,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage is reset as well so the head (and the outputs derived from it)
  // shows a defined value straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_VAL;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the control/decoder.
// Owns the PC, issues in-order word requests to instruction memory and buffers
// returned words in a DEPTH-entry prefetch FIFO. A redirect (pc_src) flushes the
// FIFO, reloads the PC and discards every word still in flight.
// Optional build macro: FETCH_STATS_EN adds saturating statistics counters
//   stat_fetched (words pushed), stat_dropped (words discarded),
//   stat_starve (cycles in RUN with no valid instruction).
// Ports:
//   clk          in   clock
//   reset        in   asynchronous active-low reset
//   imem_req     out  request valid, address on imem_addr
//   imem_addr    out  word-aligned fetch address
//   imem_gnt     in   request accepted (req & gnt = issue)
//   imem_rvalid  in   response valid, responses return in issue order
//   imem_rdata   in   response instruction word
//   pc_src       in   redirect request (taken branch / PC write)
//   pc_target    in   redirect address
//   dec_ready    in   head instruction consumed this cycle
//   instr_valid  out  head instruction valid
//   instr        out  head instruction word
//   op/cond/funct/rd  out  fields sliced from instr
//   pc_plus8     out  head instruction address + 8
module fetch_unit
  import mycpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic              dec_ready,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [1:0]        op,
  output logic [3:0]        cond,
  output logic [5:0]        funct,
  output logic [3:0]        rd,
  output logic [ADDR_W-1:0] pc_plus8
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_dropped,
  output logic [31:0]       stat_starve
`endif
);

  localparam int FCNT_W = $clog2(DEPTH) + 1;
  // One extra bit so fifo_count + outstanding never wraps in the credit check.
  localparam int CNT_W  = FCNT_W + 1;
  localparam int ENT_W  = 32 + ADDR_W;

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop;
  logic [CNT_W-1:0]  out_nxt;
  logic [CNT_W-1:0]  drop_nxt;
  logic [CNT_W-1:0]  fcnt;
  logic [CNT_W-1:0]  fcnt_nxt;
  logic              req_nxt;

  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [ENT_W-1:0]  head;
  logic [ADDR_W-1:0] head_addr;

  logic              issue;
  logic              rv_drop;
  logic              rv_keep;
  logic              push;
  logic              pop;

  assign issue   = imem_req && imem_gnt;
  // A response first pays off the discard debt, otherwise it is a live word.
  assign rv_drop = imem_rvalid && (drop != '0);
  assign rv_keep = imem_rvalid && (drop == '0);
  // A redirect wins: same-cycle live response and pop are ignored.
  assign push    = rv_keep && !pc_src;
  assign pop     = instr_valid && dec_ready && !pc_src;
  assign fcnt    = CNT_W'(fifo_count);

  always_comb begin
    drop_nxt  = drop - CNT_W'(rv_drop);
    out_nxt   = outstanding + CNT_W'(issue) - CNT_W'(rv_keep);
    fcnt_nxt  = fcnt + CNT_W'(push) - CNT_W'(pop);
    if (pc_src) begin
      // Every word still owed by memory after this cycle (including one issued
      // now) becomes stale. A word arriving this very cycle is already retired
      // from the owed total above, so it is discarded without being counted twice.
      drop_nxt = drop_nxt + out_nxt;
      out_nxt  = '0;
      fcnt_nxt = '0;
    end

    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (pc_src && (drop_nxt != '0)) state_nxt = DRAIN;
      DRAIN:   if (drop_nxt == '0) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase

    // Request is registered: it is computed from next-cycle occupancy so the
    // credit rule fifo_count + outstanding < DEPTH holds when it is presented.
    req_nxt = (state_nxt == RUN) && ((fcnt_nxt + out_nxt) < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      imem_req    <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      drop        <= drop_nxt;
      imem_req    <= req_nxt;
      if (pc_src) begin
        pc <= pc_target;
      end else if (issue) begin
        pc <= pc + ADDR_W'(4);
      end
    end
  end

  assign imem_addr = pc;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .WIDTH   (ENT_W),
    .RST_VAL ({32'h0000_0000, RESET_PC})
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({imem_rdata, imem_addr_of_resp(outstanding)}),
    .pop   (pop),
    .flush (pc_src),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Address of the word returning now: responses are in order, so it is the
  // PC minus the number of words still owed (outstanding counts this one).
  function automatic logic [ADDR_W-1:0] imem_addr_of_resp(input logic [CNT_W-1:0] owed);
    return pc - (ADDR_W'(owed) << 2);
  endfunction

  assign instr_valid = !fifo_empty;
  assign instr       = head[ENT_W-1:ADDR_W];
  assign head_addr   = head[ADDR_W-1:0];
  assign pc_plus8    = head_addr + ADDR_W'(8);
  assign cond        = instr[COND_HI:COND_LO];
  assign op          = instr[OP_HI:OP_LO];
  assign funct       = instr[FUNCT_HI:FUNCT_LO];
  assign rd          = instr[RD_HI:RD_LO];

`ifdef FETCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) begin
      return v + 32'd1;
    end
    return v;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fetched <= '0;
      stat_dropped <= '0;
      stat_starve  <= '0;
    end else begin
      stat_fetched <= sat_inc(stat_fetched, push);
      stat_dropped <= sat_inc(stat_dropped, imem_rvalid && !push);
      stat_starve  <= sat_inc(stat_starve, (state == RUN) && !instr_valid);
    end
  end
`endif

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!reset)
    !(imem_rvalid && (outstanding == '0) && (drop == '0)));

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        imem_req, imem_gnt, imem_rvalid, pc_src, dec_ready, instr_valid;
  logic [31:0] imem_addr, imem_rdata, pc_target, instr, pc_plus8;
  logic [1:0]  op;
  logic [3:0]  cond, rd;
  logic [5:0]  funct;

  logic        req_w, gnt_w, rvalid_w, pcsrc_w, ready_w, valid_w;
  logic [31:0] addr_w, rdata_w, target_w, instr_w, pc8_w;
  logic [1:0]  op_w;
  logic [3:0]  cond_w, rd_w;
  logic [5:0]  funct_w;

`ifdef FETCH_STATS_EN
  logic [31:0] st_fetched, st_dropped, st_starve;
  logic [31:0] st_fetched_w, st_dropped_w, st_starve_w;
`endif

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_src(pc_src), .pc_target(pc_target), .dec_ready(dec_ready),
    .instr_valid(instr_valid), .instr(instr), .op(op), .cond(cond),
    .funct(funct), .rd(rd), .pc_plus8(pc_plus8)
`ifdef FETCH_STATS_EN
    , .stat_fetched(st_fetched), .stat_dropped(st_dropped), .stat_starve(st_starve)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset),
    .imem_req(req_w), .imem_addr(addr_w), .imem_gnt(gnt_w),
    .imem_rvalid(rvalid_w), .imem_rdata(rdata_w),
    .pc_src(pcsrc_w), .pc_target(target_w), .dec_ready(ready_w),
    .instr_valid(valid_w), .instr(instr_w), .op(op_w), .cond(cond_w),
    .funct(funct_w), .rd(rd_w), .pc_plus8(pc8_w)
`ifdef FETCH_STATS_EN
    , .stat_fetched(st_fetched_w), .stat_dropped(st_dropped_w), .stat_starve(st_starve_w)
`endif
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        resp_en;
  logic [31:0] mq[$];
  logic [31:0] mq_w[$];
  logic [31:0] log_w[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] b;
    b = a[9:2];
    return {b, b, b, b} ^ 32'hC6A5_3E10;
  endfunction

  // one clock: record issues before the edge, present in-order responses after it
  task automatic tick();
    logic [31:0] a;
    if (imem_req && imem_gnt) mq.push_back(imem_addr);
    if (req_w && gnt_w) begin
      mq_w.push_back(addr_w);
      if (log_w.size() < 3) log_w.push_back(addr_w);
    end
    @(posedge clk);
    #1;
    if (resp_en && (mq.size() > 0)) begin
      a = mq.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(a);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    if (mq_w.size() > 0) begin
      a = mq_w.pop_front();
      rvalid_w = 1'b1;
      rdata_w  = word_at(a);
    end else begin
      rvalid_w = 1'b0;
      rdata_w  = 32'h0;
    end
  endtask

  task automatic reset_dut();
    reset       = 1'b0;
    pc_src      = 1'b0;
    imem_rvalid = 1'b0;
    rvalid_w    = 1'b0;
    mq.delete();
    mq_w.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!instr_valid && (n < 10)) begin
      tick();
      n++;
    end
    check_val(tag, instr_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_iss;
    logic [31:0] lw;
    reset = 1'b0; imem_gnt = 1'b1; dec_ready = 1'b1; pc_src = 1'b0; pc_target = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; resp_en = 1'b1;
    gnt_w = 1'b1; ready_w = 1'b1; pcsrc_w = 1'b0; target_w = 32'h0;
    rvalid_w = 1'b0; rdata_w = 32'h0;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    check_val("rst_req", imem_req, 0);
    check_val("rst_valid", instr_valid, 0);
    check_val("rst_instr", instr, 0);
    check_val("rst_pc8", pc_plus8, 32'h8);
    check_val("rst_pc8_wrap", pc8_w, 32'h0);
    check_val("rst_req_wrap", req_w, 0);
`ifdef FETCH_STATS_EN
    check_val("rst_stat_f", st_fetched, 0);
    check_val("rst_stat_s", st_starve, 0);
`endif

    // test 1: streaming fetch, latency 1
    reset = 1'b1;
    check_val("t1_idle_req", imem_req, 0);
    tick();
    check_val("t1_req0", imem_req, 1);
    check_val("t1_addr0", imem_addr, 32'h0);
    tick();
    check_val("t1_req1", imem_req, 1);
    check_val("t1_addr1", imem_addr, 32'h4);
    check_val("t1_nvalid", instr_valid, 0);
    tick();
    check_val("t1_valid", instr_valid, 1);
    check_val("t1_instr0", instr, word_at(32'h0));
    check_val("t1_pc8_0", pc_plus8, 32'h8);
    check_val("t1_credit", imem_req, 0);
    check_val("t1_cond", cond, 4'hC);
    check_val("t1_op", op, 2'h1);
    check_val("t1_funct", funct, 6'h2A);
    check_val("t1_rd", rd, 4'h3);
    check_val("t6_valid_w", valid_w, 1);
    check_val("t6_pc8_w", pc8_w, 32'h0);
    tick();
    check_val("t1_instr1", instr, word_at(32'h4));
    check_val("t1_pc8_1", pc_plus8, 32'hC);
    check_val("t1_req2", imem_req, 1);
    check_val("t1_addr2", imem_addr, 32'h8);
`ifdef FETCH_STATS_EN
    check_val("t1_stat_f", st_fetched, 2);
    check_val("t1_stat_s", st_starve, 2);
    check_val("t1_stat_d", st_dropped, 0);
`endif
    tick();
    check_val("t6_nissue_w", log_w.size(), 3);
    for (int i = 0; i < 3; i++) begin
      lw = (log_w.size() > i) ? log_w[i] : 32'hDEAD_BEEF;
      check_val($sformatf("t6_addr_w%0d", i), lw, (i == 0) ? 32'hFFFF_FFF8 :
                                                  (i == 1) ? 32'hFFFF_FFFC : 32'h0);
    end

    // test 2: decoder stalled, FIFO fills to DEPTH, then drains in order
    reset_dut();
    reset = 1'b1; dec_ready = 1'b0;
    n_iss = 0;
    for (int i = 0; i < 12; i++) begin
      if (imem_req && imem_gnt) n_iss++;
      tick();
    end
    check_val("t2_nissue", n_iss, 2);
    check_val("t2_full_req", imem_req, 0);
    check_val("t2_valid", instr_valid, 1);
    check_val("t2_head", instr, word_at(32'h0));
    dec_ready = 1'b1;
    tick();
    check_val("t2_second", instr, word_at(32'h4));
    check_val("t2_pc8", pc_plus8, 32'hC);
    check_val("t2_req", imem_req, 1);
    check_val("t2_addr", imem_addr, 32'h8);
    tick();
    wait_valid("t2_resume_valid");
    check_val("t2_third", instr, word_at(32'h8));
    check_val("t2_third_pc8", pc_plus8, 32'h10);

    // test 3: redirect with two words in flight
    reset_dut();
    reset = 1'b1; dec_ready = 1'b1; resp_en = 1'b0;
    tick(); tick(); tick();
    check_val("t3_stall_req", imem_req, 0);
    pc_src = 1'b1; pc_target = 32'h100; resp_en = 1'b1;
    tick();
    pc_src = 1'b0;
    check_val("t3_drain_req0", imem_req, 0);
    check_val("t3_drain_nv0", instr_valid, 0);
    tick();
    check_val("t3_drain_req1", imem_req, 0);
    check_val("t3_drain_nv1", instr_valid, 0);
    tick();
    check_val("t3_run_req", imem_req, 1);
    check_val("t3_run_addr", imem_addr, 32'h100);
    check_val("t3_run_nv", instr_valid, 0);
`ifdef FETCH_STATS_EN
    check_val("t3_stat_d", st_dropped, 2);
    check_val("t3_stat_f", st_fetched, 0);
    check_val("t3_stat_s", st_starve, 3);
`endif
    tick();
    wait_valid("t3_tgt_valid");
    check_val("t3_tgt_instr", instr, 32'h86E5_7E50);
    check_val("t3_tgt_pc8", pc_plus8, 32'h108);
    check_val("t3_cond", cond, 4'h8);
    check_val("t3_op", op, 2'h1);
    check_val("t3_funct", funct, 6'h2E);
    check_val("t3_rd", rd, 4'h7);

    // test 4: redirect in the same cycle as a response and a pop
    reset_dut();
    reset = 1'b1; dec_ready = 1'b1; resp_en = 1'b1;
    tick(); tick(); tick();
    check_val("t4_pre_valid", instr_valid, 1);
    check_val("t4_pre_rvalid", imem_rvalid, 1);
    pc_src = 1'b1; pc_target = 32'h200;
    tick();
    pc_src = 1'b0;
    check_val("t4_flushed", instr_valid, 0);
    check_val("t4_req", imem_req, 1);
    check_val("t4_addr", imem_addr, 32'h200);
`ifdef FETCH_STATS_EN
    check_val("t4_stat_d", st_dropped, 1);
    check_val("t4_stat_f", st_fetched, 1);
`endif
    wait_valid("t4_tgt_valid");
    check_val("t4_tgt_instr", instr, word_at(32'h200));
    check_val("t4_tgt_pc8", pc_plus8, 32'h208);

    // test 5: reset asserted mid-transaction
    reset_dut();
    reset = 1'b1; dec_ready = 1'b0; resp_en = 1'b1;
    tick(); tick(); tick();
    check_val("t5_pre_valid", instr_valid, 1);
    reset = 1'b0;
    #1;
    check_val("t5_req", imem_req, 0);
    check_val("t5_valid", instr_valid, 0);
    check_val("t5_instr", instr, 0);
    check_val("t5_pc8", pc_plus8, 32'h8);
    check_val("t5_pc8_w", pc8_w, 32'h0);
`ifdef FETCH_STATS_EN
    check_val("t5_stat_f", st_fetched, 0);
    check_val("t5_stat_d", st_dropped, 0);
    check_val("t5_stat_s", st_starve, 0);
`endif
    reset_dut();
    reset = 1'b1; dec_ready = 1'b1;
    tick();
    check_val("t5_restart_req", imem_req, 1);
    check_val("t5_restart_addr", imem_addr, 32'h0);
    tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
